pll_lock_supervisor: RTL and testbench

- Sits directly downstream of the 5x pixel-clock rPLL; runs on the free-running 27 MHz PLL input clock.
- Drives the PLL reset and qualifies the PLL lock output: debounce, timeout, retry.
- Generates the active-low reset for the pixel-clock domain, i.e. the clock divider and TMDS serializer stages.
- Counts lock-loss events for status/debug.

---
 rtl/pll_lock_supervisor.sv | 151 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock qualifier for the 5x pixel-clock rPLL. It debounces lock,
// retries on timeout and releases the pixel-domain reset. Optional macro: PLL_LOCK_SYNC_EN.
module pll_lock_supervisor #(
  parameter int unsigned RST_CYCLES    = 16,
  parameter int unsigned LOCK_TIMEOUT  = 27000,
  parameter int unsigned STABLE_CYCLES = 2700,
  parameter int unsigned DROP_FILTER   = 4,
  parameter int unsigned MAX_RETRY     = 7,
  parameter int unsigned CNT_W         = 16,
  parameter int unsigned RETRY_W       = 3
) (
  input  logic               clkin,
  input  logic               reset_n,
  input  logic               pll_lock,
  output logic               pll_reset,
  output logic               pix_rst_n,
  output logic               pll_ready,
  output logic               pll_fail,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [7:0]         lock_loss_cnt
);

  typedef enum logic [1:0] {StPllRst, StWaitLock, StStable, StRun} state_e;

  localparam logic [CNT_W-1:0]   RstLast     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   StableLast  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   DropLast    = CNT_W'(DROP_FILTER - 1);
  localparam logic [RETRY_W-1:0] RetryLimit  = RETRY_W'(MAX_RETRY);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic               lock_q;
  logic [RETRY_W-1:0] retry_inc;
  logic [7:0]         loss_inc;

`ifdef PLL_LOCK_SYNC_EN
  logic [1:0] lock_sync;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      lock_sync <= 2'b00;
    end else begin
      lock_sync <= {lock_sync[0], pll_lock};
    end
  end

  assign lock_q = lock_sync[1];
`else
  assign lock_q = pll_lock;
`endif

  assign retry_inc = (&retry_cnt) ? retry_cnt : retry_cnt + 1'b1;
  assign loss_inc  = (&lock_loss_cnt) ? lock_loss_cnt : lock_loss_cnt + 8'd1;

  // Every state exit clears cnt, so the == compares never see a wrapped counter.
  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      state         <= StPllRst;
      cnt           <= '0;
      pll_reset     <= 1'b1;
      pix_rst_n     <= 1'b0;
      pll_ready     <= 1'b0;
      pll_fail      <= 1'b0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else begin
      case (state)
        StPllRst: begin
          pll_reset <= 1'b1;
          pix_rst_n <= 1'b0;
          pll_ready <= 1'b0;
          if (cnt == RstLast) begin
            cnt       <= '0;
            pll_reset <= 1'b0;
            state     <= StWaitLock;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StWaitLock: begin
          // A lock arriving on the timeout cycle takes priority over the retry.
          if (lock_q) begin
            cnt   <= '0;
            state <= StStable;
          end else if (cnt == TimeoutLast) begin
            cnt       <= '0;
            retry_cnt <= retry_inc;
            if (retry_inc == RetryLimit) begin
              pll_fail <= 1'b1;
            end
            pll_reset <= 1'b1;
            state     <= StPllRst;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StStable: begin
          if (!lock_q) begin
            cnt   <= '0;
            state <= StWaitLock;
          end else if (cnt == StableLast) begin
            cnt       <= '0;
            retry_cnt <= '0;
            state     <= StRun;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        StRun: begin
          // cnt tracks consecutive low lock samples; shorter dips are glitches.
          if (lock_q) begin
            cnt       <= '0;
            pix_rst_n <= 1'b1;
            pll_ready <= 1'b1;
          end else if (cnt == DropLast) begin
            cnt           <= '0;
            lock_loss_cnt <= loss_inc;
            pix_rst_n     <= 1'b0;
            pll_ready     <= 1'b0;
            pll_reset     <= 1'b1;
            state         <= StPllRst;
          end else begin
            cnt       <= cnt + 1'b1;
            pix_rst_n <= 1'b1;
            pll_ready <= 1'b1;
          end
        end

        default: begin
          cnt       <= '0;
          pll_reset <= 1'b1;
          pix_rst_n <= 1'b0;
          pll_ready <= 1'b0;
          state     <= StPllRst;
        end
      endcase
    end
  end

`ifndef SYNTHESIS
  ready_matches_pix: assert property (@(posedge clkin) disable iff (!reset_n)
    pll_ready == pix_rst_n);
  no_pix_during_pll_reset: assert property (@(posedge clkin) disable iff (!reset_n)
    pll_reset |-> !pix_rst_n);
`endif

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor with shortened timing parameters.
// Latencies shift by two cycles when PLL_LOCK_SYNC_EN is defined.
module tb_pll_lock_supervisor;

  localparam int unsigned RST_CYCLES    = 4;
  localparam int unsigned LOCK_TIMEOUT  = 20;
  localparam int unsigned STABLE_CYCLES = 10;
  localparam int unsigned DROP_FILTER   = 3;
  localparam int unsigned MAX_RETRY     = 2;
`ifdef PLL_LOCK_SYNC_EN
  localparam int SD = 2;
`else
  localparam int SD = 0;
`endif

  logic       clkin;
  logic       reset_n;
  logic       pll_lock;
  logic       pll_reset;
  logic       pix_rst_n;
  logic       pll_ready;
  logic       pll_fail;
  logic [2:0] retry_cnt;
  logic [7:0] lock_loss_cnt;

  logic [31:0] exp_q[$];
  logic [31:0] exp;
  int          vectors;
  int          miscompares;

  pll_lock_supervisor #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .DROP_FILTER  (DROP_FILTER),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (16),
    .RETRY_W      (3)
  ) dut (
    .clkin        (clkin),
    .reset_n      (reset_n),
    .pll_lock     (pll_lock),
    .pll_reset    (pll_reset),
    .pix_rst_n    (pix_rst_n),
    .pll_ready    (pll_ready),
    .pll_fail     (pll_fail),
    .retry_cnt    (retry_cnt),
    .lock_loss_cnt(lock_loss_cnt)
  );

  initial clkin = 1'b0;
  always #5 clkin = ~clkin;

  task automatic tick();
    @(posedge clkin);
    #1;
  endtask

  // Edges until the chosen output reaches val; -1 if it never does within the bound.
  task automatic wait_for(input bit sel_pix, input logic val, output int n);
    n = 0;
    while (((sel_pix ? pix_rst_n : pll_reset) !== val) && n < 200) begin
      tick();
      n++;
    end
    if ((sel_pix ? pix_rst_n : pll_reset) !== val) n = -1;
  endtask

  task automatic test_reset();
    reset_n  = 1'b1;
    pll_lock = 1'b0;
    #2;
    reset_n = 1'b0;
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    #1;
    exp = exp_q.pop_front(); vectors++;
    if (32'(pll_reset) !== exp) begin miscompares++; $display("FAIL rst_pll_reset got %0d want %0d", pll_reset, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(pix_rst_n) !== exp) begin miscompares++; $display("FAIL rst_pix_rst_n got %0d want %0d", pix_rst_n, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(pll_ready) !== exp) begin miscompares++; $display("FAIL rst_pll_ready got %0d want %0d", pll_ready, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(pll_fail) !== exp) begin miscompares++; $display("FAIL rst_pll_fail got %0d want %0d", pll_fail, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(retry_cnt) !== exp) begin miscompares++; $display("FAIL rst_retry_cnt got %0d want %0d", retry_cnt, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(lock_loss_cnt) !== exp) begin miscompares++; $display("FAIL rst_lock_loss got %0d want %0d", lock_loss_cnt, exp); end
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_nominal();
    int n;
    exp_q.push_back(RST_CYCLES);
    wait_for(1'b0, 1'b0, n);
    exp = exp_q.pop_front(); vectors++;
    if (32'(n) !== exp) begin miscompares++; $display("FAIL nom_pll_reset_len got %0d want %0d", n, exp); end
    repeat (5) tick();
    pll_lock = 1'b1;
    // Latency counted from the first edge that samples the raised lock.
    exp_q.push_back(STABLE_CYCLES + 1 + SD); exp_q.push_back(1); exp_q.push_back(0);
    wait_for(1'b1, 1'b1, n);
    exp = exp_q.pop_front(); vectors++;
    if (32'(n - 1) !== exp) begin miscompares++; $display("FAIL nom_pix_latency got %0d want %0d", n - 1, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(pll_ready) !== exp) begin miscompares++; $display("FAIL nom_pll_ready got %0d want %0d", pll_ready, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(retry_cnt) !== exp) begin miscompares++; $display("FAIL nom_retry_cnt got %0d want %0d", retry_cnt, exp); end
  endtask

  task automatic test_glitch();
    int n;
    bit pix_ok;
    exp_q.push_back(1); exp_q.push_back(0);
    repeat (2) tick();
    pix_ok   = 1'b1;
    pll_lock = 1'b0;
    repeat (DROP_FILTER - 1) begin tick(); if (pix_rst_n !== 1'b1) pix_ok = 1'b0; end
    pll_lock = 1'b1;
    repeat (6) begin tick(); if (pix_rst_n !== 1'b1) pix_ok = 1'b0; end
    exp = exp_q.pop_front(); vectors++;
    if (32'(pix_ok) !== exp) begin miscompares++; $display("FAIL glitch_pix_held got %0d want %0d", pix_ok, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(lock_loss_cnt) !== exp) begin miscompares++; $display("FAIL glitch_loss_cnt got %0d want %0d", lock_loss_cnt, exp); end

    exp_q.push_back(DROP_FILTER + SD); exp_q.push_back(1); exp_q.push_back(1);
    pll_lock = 1'b0;
    wait_for(1'b1, 1'b0, n);
    exp = exp_q.pop_front(); vectors++;
    if (32'(n) !== exp) begin miscompares++; $display("FAIL drop_pix_latency got %0d want %0d", n, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(lock_loss_cnt) !== exp) begin miscompares++; $display("FAIL drop_loss_cnt got %0d want %0d", lock_loss_cnt, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(pll_reset) !== exp) begin miscompares++; $display("FAIL drop_pll_reset got %0d want %0d", pll_reset, exp); end
  endtask

  task automatic test_async_reset();
    int n;
    exp_q.push_back(1);
    pll_lock = 1'b1;
    wait_for(1'b1, 1'b1, n);
    exp = exp_q.pop_front(); vectors++;
    if (32'(pix_rst_n) !== exp) begin miscompares++; $display("FAIL relock_pix got %0d want %0d", pix_rst_n, exp); end
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0);
    exp_q.push_back(0); exp_q.push_back(0); exp_q.push_back(0);
    tick();
    #3;
    reset_n = 1'b0;
    #1;
    exp = exp_q.pop_front(); vectors++;
    if (32'(pix_rst_n) !== exp) begin miscompares++; $display("FAIL async_pix got %0d want %0d", pix_rst_n, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(pll_reset) !== exp) begin miscompares++; $display("FAIL async_pll_reset got %0d want %0d", pll_reset, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(pll_ready) !== exp) begin miscompares++; $display("FAIL async_ready got %0d want %0d", pll_ready, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(pll_fail) !== exp) begin miscompares++; $display("FAIL async_fail got %0d want %0d", pll_fail, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(retry_cnt) !== exp) begin miscompares++; $display("FAIL async_retry got %0d want %0d", retry_cnt, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(lock_loss_cnt) !== exp) begin miscompares++; $display("FAIL async_loss_cnt got %0d want %0d", lock_loss_cnt, exp); end
    pll_lock = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic test_unstable();
    int n;
    bit pix_low;
    wait_for(1'b0, 1'b0, n);
    pll_lock = 1'b1;
    repeat (1 + SD) tick();
    repeat (6) tick();
    pll_lock = 1'b0;
    // Back in WAIT_LOCK after 1+SD edges, then a full fresh timeout.
    exp_q.push_back(1 + SD + LOCK_TIMEOUT); exp_q.push_back(1);
    exp_q.push_back(1); exp_q.push_back(0);
    pix_low = 1'b1;
    n = 0;
    while (pll_reset !== 1'b1 && n < 200) begin
      tick();
      n++;
      if (pix_rst_n !== 1'b0) pix_low = 1'b0;
    end
    if (pll_reset !== 1'b1) n = -1;
    exp = exp_q.pop_front(); vectors++;
    if (32'(n) !== exp) begin miscompares++; $display("FAIL unstable_timeout got %0d want %0d", n, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(pix_low) !== exp) begin miscompares++; $display("FAIL unstable_pix_low got %0d want %0d", pix_low, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(retry_cnt) !== exp) begin miscompares++; $display("FAIL unstable_retry got %0d want %0d", retry_cnt, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(pll_fail) !== exp) begin miscompares++; $display("FAIL unstable_fail got %0d want %0d", pll_fail, exp); end
  endtask

  task automatic test_timeout();
    int n1;
    int n2;
    int n;
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(RST_CYCLES + LOCK_TIMEOUT);
      exp_q.push_back(k + 2);
      exp_q.push_back(1);
      wait_for(1'b0, 1'b0, n1);
      wait_for(1'b0, 1'b1, n2);
      n = (n1 < 0 || n2 < 0) ? -1 : n1 + n2;
      exp = exp_q.pop_front(); vectors++;
      if (32'(n) !== exp) begin miscompares++; $display("FAIL timeout_period%0d got %0d want %0d", k, n, exp); end
      exp = exp_q.pop_front(); vectors++;
      if (32'(retry_cnt) !== exp) begin miscompares++; $display("FAIL timeout_retry%0d got %0d want %0d", k, retry_cnt, exp); end
      exp = exp_q.pop_front(); vectors++;
      if (32'(pll_fail) !== exp) begin miscompares++; $display("FAIL timeout_fail%0d got %0d want %0d", k, pll_fail, exp); end
    end
  endtask

  task automatic test_sticky_fail();
    int n;
    exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    pll_lock = 1'b1;
    wait_for(1'b1, 1'b1, n);
    exp = exp_q.pop_front(); vectors++;
    if (32'(pix_rst_n) !== exp) begin miscompares++; $display("FAIL sticky_pix got %0d want %0d", pix_rst_n, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(retry_cnt) !== exp) begin miscompares++; $display("FAIL sticky_retry got %0d want %0d", retry_cnt, exp); end
    exp = exp_q.pop_front(); vectors++;
    if (32'(pll_fail) !== exp) begin miscompares++; $display("FAIL sticky_fail got %0d want %0d", pll_fail, exp); end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    test_reset();
    test_nominal();
    test_glitch();
    test_async_reset();
    test_unstable();
    test_timeout();
    test_sticky_fail();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
